onehot_rr_arbiter: RTL and testbench
====================================

# onehot_rr_arbiter

Round-robin arbiter that turns N request lines into a registered, one-hot grant with a valid/ready handshake. It sits directly upstream of the one-hot-to-binary encoder: its `grant` vector is the encoder's input. The handshake holds the grant stable until the downstream consumer of the encoded index accepts it. The output is always one-hot or all-zero, so the encoder's default branch is reached only when `grant_valid` is low.

## Interface
- `N`, 4, number of requesters; legal values 2..8 (2 feeds the 2:1 encoder, 4 feeds the 4:2 encoder)
- `clk` input 1, single clock, all state on rising edge
- `rst_n` input 1, reset is asynchronous and active-low
- `req` input N, request lines, level-sensitive, bit i = requester i
- `grant` output N, registered one-hot grant; all-zero when `grant_valid`=0
- `grant_valid` output 1, registered; `grant` holds a live offer
- `grant_ready` input 1, downstream accepts the current offer this cycle

## Operation
- State machine, 2 states:
  - IDLE: no offer.
  - OFFER: an offer is held.
- Priority pointer `ptr` (log2 N bits), reset 0. Winner is the first set bit of `req` scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
- IDLE:
  - `req`≠0: register the winner into `grant`, set `grant_valid`=1, go to OFFER.
  - `req`=0: stay in IDLE, `grant`=0.
- OFFER with `grant_ready`=0: hold `grant` and `grant_valid` unchanged.
  - The grant is sticky. Deasserting the granted `req` bit does not withdraw the offer.
  - New requests do not preempt the offer.
- OFFER with `grant_ready`=1 (transfer):
  - `ptr` ← (index of current grant + 1) mod N.
  - Arbitrate the same-cycle `req` using the new `ptr`.
  - If a winner exists, load it and stay in OFFER (back-to-back, no bubble).
  - Otherwise `grant`←0, `grant_valid`←0, go to IDLE.
  - A requester whose bit stays high after its own transfer gets lowest priority next.
- `grant_ready` in IDLE is ignored.
- Reset values:
  - state=IDLE
  - `grant`=0
  - `grant_valid`=0
  - `ptr`=0
- Reset asserted mid-offer clears the outputs immediately (asynchronously), with no transfer recorded.
- Invariant: `grant` has popcount 1 when `grant_valid`=1 and popcount 0 otherwise.

## Timing
- Latency from `req` rising in IDLE to `grant_valid` high: 1 cycle.
- Transfer occurs on the rising edge where `grant_valid`=1 and `grant_ready`=1.
- Sustained throughput is 1 grant per cycle when `grant_ready` is held high and requests are continuous.
- No combinational path from `req` or `grant_ready` to any output.
- `rst_n` deassertion is synchronised externally. The first arbitration happens on the first edge after release.

## Structure
- Shared package `arb_pkg` holds:
  - the state enum (IDLE, OFFER)
  - the default requester count `ARB_N`=4
  - a `clog2`-style width constant for `ptr`
- One sub-module, `rr_pick`. It is purely combinational:
  - Inputs: `req` and `ptr`.
  - Outputs: one-hot `pick` and `pick_idx`.
  - Implementation: a double-width masked priority scan.
- The top module holds only the FSM, the `ptr` register and the output registers.

## Test plan
- Reset then single request:
  - Stimulus: N=4, hold `rst_n`=0, then release. Drive `req`=4'b0100, `grant_ready`=1.
  - Required: next cycle `grant`=4'b0100, `grant_valid`=1. Following cycle `ptr`=3. Drop `req`, and `grant_valid`=0.
- Round-robin fairness:
  - Stimulus: `req`=4'b1111 held, `grant_ready`=1.
  - Required: grants cycle 0001→0010→0100→1000→0001 with no idle cycle between them.
- Backpressure stickiness:
  - Stimulus: `req`=4'b0011, `grant_ready`=0 for 5 cycles, during which req[0] drops.
  - Required: `grant` stays 4'b0001 and `grant_valid` stays 1 throughout. After `grant_ready`=1 for one cycle, the next grant is 4'b0010.
- Pointer wrap:
  - Stimulus: with `ptr`=3, drive `req`=4'b0101.
  - Required: `grant`=4'b0001. After transfer, `ptr`=1 and the next grant is 4'b0100.
- Reset mid-offer:
  - Stimulus: `grant_valid`=1 with `grant`=4'b1000. Pulse `rst_n` low between clock edges.
  - Required: `grant`=0 and `grant_valid`=0 immediately. `ptr`=0 after release. Re-request `req`=4'b1001 and the grant is 4'b0001.
- N=2 instance:
  - Stimulus: `req`=2'b11, `grant_ready`=1.
  - Required: grants alternate 01, 10, 01. Assertion checks one-hot or zero on every cycle.

Source files
------------

// File: rtl/onehot_rr_arbiter_pkg.sv
// Shared definitions for the one-hot round-robin arbiter slice.
//   state_t   : arbiter FSM states (IDLE, OFFER)
//   ARB_N     : default requester count
//   ptr_w()   : width of the priority pointer / grant index for n requesters
//   ARB_PTR_W : pointer width for the default requester count
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  localparam int ARB_N = 4;

  // clog2 with a floor of 1 so a 2-requester pointer is still one bit wide
  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int ARB_PTR_W = ptr_w(ARB_N);

endpackage

// File: rtl/onehot_rr_arbiter_if.sv
// Request/grant bundle between requesters, the arbiter and the downstream
// one-hot-to-binary encoder.
//   req         : request lines, bit i = requester i
//   grant       : one-hot grant (all-zero when grant_valid is low)
//   grant_valid : grant holds a live offer
//   grant_ready : downstream accepts the current offer this cycle
// Modports: master = arbiter side, slave = requester/consumer side.
interface onehot_rr_arbiter_if
  import arb_pkg::*;
#(
  parameter int N = ARB_N
);

  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic         grant_ready;

  modport master (
    input  req,
    input  grant_ready,
    output grant,
    output grant_valid
  );

  modport slave (
    output req,
    output grant_ready,
    input  grant,
    input  grant_valid
  );

endinterface

// File: rtl/onehot_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selection.
//   req      : request lines
//   ptr      : highest-priority requester index
//   pick     : one-hot winner (all-zero when no request)
//   pick_idx : binary index of the winner (0 when no request)
//   any      : at least one request present
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = ARB_N,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [PW-1:0] pick_idx,
  output logic          any
);

  logic [2*N-1:0] masked;
  logic           found;
  int unsigned    sel;

  // Lower copy has bits below ptr masked off, upper copy is the full vector:
  // the first set bit of the doubled vector is the wrap-around winner.
  always_comb begin
    masked = {req, req};
    for (int unsigned k = 0; k < N; k++) begin
      if (k < 32'(ptr)) masked[k] = 1'b0;
    end

    found = 1'b0;
    sel   = 0;
    for (int unsigned k = 0; k < 2 * N; k++) begin
      if (!found && masked[k]) begin
        found = 1'b1;
        sel   = k;
      end
    end

    pick_idx = (sel >= N) ? PW'(sel - N) : PW'(sel);

    pick = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pick[k] = found && (32'(pick_idx) == k);
    end

    any = found;
  end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter: round-robin arbiter producing a registered one-hot grant
// with a valid/ready handshake. An offer is held (sticky, non-preemptible)
// until grant_ready; on transfer the pointer moves past the granted requester
// and the same-cycle requests are re-arbitrated, giving one grant per cycle.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : request/grant bundle (master modport)
module onehot_rr_arbiter
  import arb_pkg::*;
#(
  parameter int N = ARB_N
) (
  input  logic                   clk,
  input  logic                   rst_n,
  onehot_rr_arbiter_if.master    bus
);

  localparam int PW = ptr_w(N);

  state_t        state, state_n;
  logic [PW-1:0] ptr, ptr_n;
  logic [PW-1:0] gidx, gidx_n;
  logic [N-1:0]  grant, grant_n;
  logic          valid, valid_n;

  logic [PW-1:0] next_ptr;
  logic [PW-1:0] scan_ptr;
  logic [N-1:0]  pick;
  logic [PW-1:0] pick_idx;
  logic          any;

  // Pointer value that a transfer of the current grant would produce.
  assign next_ptr = (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;

  // While offering, the picker already looks ahead with the post-transfer
  // pointer so a transfer can reload back-to-back without a bubble.
  assign scan_ptr = (state == OFFER) ? next_ptr : ptr;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req      (bus.req),
    .ptr      (scan_ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      gidx  <= '0;
      grant <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      gidx  <= gidx_n;
      grant <= grant_n;
      valid <= valid_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gidx_n  = gidx;
    grant_n = grant;
    valid_n = valid;

    unique case (state)
      IDLE: begin
        if (any) begin
          grant_n = pick;
          gidx_n  = pick_idx;
          valid_n = 1'b1;
          state_n = OFFER;
        end
      end

      OFFER: begin
        if (bus.grant_ready) begin
          ptr_n = next_ptr;
          if (any) begin
            grant_n = pick;
            gidx_n  = pick_idx;
          end else begin
            grant_n = '0;
            valid_n = 1'b0;
            state_n = IDLE;
          end
        end
      end

      default: begin
        state_n = IDLE;
        grant_n = '0;
        valid_n = 1'b0;
      end
    endcase
  end

  assign bus.grant       = grant;
  assign bus.grant_valid = valid;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
module tb_onehot_rr_arbiter;

  logic clk;
  logic rst_n;

  int unsigned passed;
  int unsigned total;

  onehot_rr_arbiter_if #(.N(4)) b4 ();
  onehot_rr_arbiter_if #(.N(2)) b2 ();

  onehot_rr_arbiter #(.N(4)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4.master)
  );

  onehot_rr_arbiter #(.N(2)) u2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // First requester found scanning p, p+1, ... wrapping modulo n; -1 if none.
  function automatic int winner(input logic [7:0] r, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      if (r[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  // Behavioural model: pointer, whether an offer is outstanding, and who holds it.
  int m4_ptr, m4_idx, m2_ptr, m2_idx;
  bit m4_valid, m2_valid;

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      m4_ptr <= 0; m4_idx <= 0; m4_valid <= 1'b0;
    end else if (!m4_valid) begin
      w = winner(8'(b4.req), m4_ptr, 4);
      if (w >= 0) begin m4_valid <= 1'b1; m4_idx <= w; end
    end else if (b4.grant_ready) begin
      m4_ptr <= (m4_idx + 1) % 4;
      w = winner(8'(b4.req), (m4_idx + 1) % 4, 4);
      if (w >= 0) m4_idx <= w;
      else m4_valid <= 1'b0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      m2_ptr <= 0; m2_idx <= 0; m2_valid <= 1'b0;
    end else if (!m2_valid) begin
      w = winner(8'(b2.req), m2_ptr, 2);
      if (w >= 0) begin m2_valid <= 1'b1; m2_idx <= w; end
    end else if (b2.grant_ready) begin
      m2_ptr <= (m2_idx + 1) % 2;
      w = winner(8'(b2.req), (m2_idx + 1) % 2, 2);
      if (w >= 0) m2_idx <= w;
      else m2_valid <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("g4", 32'(b4.grant), m4_valid ? (32'd1 << m4_idx) : 32'd0);
      check("v4", 32'(b4.grant_valid), 32'(m4_valid));
      check("p4", 32'(u4.ptr), 32'(m4_ptr));
      check("oh4", 32'(b4.grant_valid ? $onehot(b4.grant) : (b4.grant == '0)), 32'd1);
      check("g2", 32'(b2.grant), m2_valid ? (32'd1 << m2_idx) : 32'd0);
      check("v2", 32'(b2.grant_valid), 32'(m2_valid));
      check("p2", 32'(u2.ptr), 32'(m2_ptr));
      check("oh2", 32'(b2.grant_valid ? $onehot(b2.grant) : (b2.grant == '0)), 32'd1);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    b4.req = '0; b4.grant_ready = 1'b0;
    b2.req = '0; b2.grant_ready = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    b4.req = '0; b4.grant_ready = 1'b0;
    b2.req = '0; b2.grant_ready = 1'b0;
    repeat (2) step();
    check("rst_grant", 32'(b4.grant), 32'h0);
    check("rst_valid", 32'(b4.grant_valid), 32'h0);
    check("rst_ptr", 32'(u4.ptr), 32'h0);
    rst_n = 1'b1;

    // Single request after reset, then pointer wrap from ptr=3.
    b4.req = 4'b0100; b4.grant_ready = 1'b1;
    step();
    check("t1_grant", 32'(b4.grant), 32'h4);
    check("t1_valid", 32'(b4.grant_valid), 32'h1);
    b4.req = 4'b0000;
    step();
    check("t1_ptr", 32'(u4.ptr), 32'h3);
    check("t1_idle", 32'(b4.grant_valid), 32'h0);
    b4.req = 4'b0101;
    step();
    check("wrap_grant", 32'(b4.grant), 32'h1);
    step();
    check("wrap_ptr", 32'(u4.ptr), 32'h1);
    check("wrap_next", 32'(b4.grant), 32'h4);
    b4.req = '0;
    step();

    // Round-robin fairness on both instances.
    do_reset();
    b4.req = 4'b1111; b4.grant_ready = 1'b1;
    b2.req = 2'b11;   b2.grant_ready = 1'b1;
    step();
    check("rr4_0", 32'(b4.grant), 32'h1);
    check("rr2_0", 32'(b2.grant), 32'h1);
    step();
    check("rr4_1", 32'(b4.grant), 32'h2);
    check("rr2_1", 32'(b2.grant), 32'h2);
    step();
    check("rr4_2", 32'(b4.grant), 32'h4);
    check("rr2_2", 32'(b2.grant), 32'h1);
    step();
    check("rr4_3", 32'(b4.grant), 32'h8);
    check("rr4_v", 32'(b4.grant_valid), 32'h1);
    step();
    check("rr4_4", 32'(b4.grant), 32'h1);

    // Backpressure: sticky grant while the granted request drops.
    do_reset();
    b4.req = 4'b0011;
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) b4.req = 4'b0010;
      step();
      check("sticky_grant", 32'(b4.grant), 32'h1);
      check("sticky_valid", 32'(b4.grant_valid), 32'h1);
    end
    b4.grant_ready = 1'b1;
    step();
    check("sticky_next", 32'(b4.grant), 32'h2);
    b4.grant_ready = 1'b0;

    // Reset pulsed low between edges while offering requester 3.
    do_reset();
    b4.req = 4'b1000;
    step();
    check("mid_grant_pre", 32'(b4.grant), 32'h8);
    #2 rst_n = 1'b0;
    #1;
    check("mid_grant", 32'(b4.grant), 32'h0);
    check("mid_valid", 32'(b4.grant_valid), 32'h0);
    check("mid_ptr", 32'(u4.ptr), 32'h0);
    #1;
    b4.req = 4'b1001;
    rst_n = 1'b1;
    step();
    check("mid_regrant", 32'(b4.grant), 32'h1);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 1500; i++) begin
      b4.req = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
      b2.req = ($urandom_range(0, 5) == 0) ? 2'b00 : 2'($urandom);
      b4.grant_ready = ($urandom_range(0, 3) != 0);
      b2.grant_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
